// File: rtl/distcalc_multi.sv
// Streaming vector-distance engine: squared-Euclidean, Euclidean (isqrt) or Manhattan over
// BEATS beats of PIPEWIDTH signed elements, with saturating accumulation and sticky overflow.
module distcalc_multi #(
  parameter int unsigned VARWIDTH  = 16,
  parameter int unsigned PIPEWIDTH = 8,
  parameter int unsigned BEATS     = 4,
  parameter int unsigned OUTWIDTH  = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [1:0]                    mode,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [VARWIDTH*PIPEWIDTH-1:0] invec0,
  input  logic [VARWIDTH*PIPEWIDTH-1:0] invec1,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [OUTWIDTH-1:0]           outval,
  output logic                          overflow
);
  localparam int unsigned DW   = VARWIDTH + 1;
  localparam int unsigned TW   = 2 * DW;
  localparam int unsigned SW   = TW + $clog2(PIPEWIDTH);
  localparam int unsigned CW   = ((SW > OUTWIDTH) ? SW : OUTWIDTH) + 1;
  localparam int unsigned HALF = OUTWIDTH / 2;
  localparam int unsigned RW   = HALF + 3;
  localparam int unsigned BW   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned QW   = (HALF > 1) ? $clog2(HALF) : 1;

  localparam logic [1:0] StAcc  = 2'd0;
  localparam logic [1:0] StSqrt = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [BW-1:0]       beat_q, beat_d;
  logic [OUTWIDTH-1:0] acc_q, acc_d;
  logic                ovf_q, ovf_d;
  logic [1:0]          mode_q, mode_d;
  logic [OUTWIDTH-1:0] result_q, result_d;
  logic [OUTWIDTH-1:0] rad_q, rad_d;
  logic [RW-3:0]       rem_q, rem_d;
  logic [HALF-1:0]     root_q, root_d;
  logic [QW-1:0]       cnt_q, cnt_d;

  logic                 first, use_abs;
  logic [1:0]           eff_mode;
  logic [CW-1:0]        sum;
  logic signed [DW-1:0] diff;
  logic signed [TW-1:0] dext;
  logic [DW-1:0]        dabs;
  logic                 sum_sat, add_sat;
  logic [OUTWIDTH-1:0]  sum_clip, acc_new;
  logic [OUTWIDTH:0]    add;
  logic                 ovf_new;

  assign first    = (beat_q == '0);
  // Mode is taken live on the first beat and from the latch on every later beat.
  assign eff_mode = first ? mode : mode_q;
  assign use_abs  = (eff_mode == 2'd2);

  always_comb begin
    sum  = '0;
    diff = '0;
    dext = '0;
    dabs = '0;
    for (int unsigned i = 0; i < PIPEWIDTH; i++) begin
      diff = DW'($signed(invec0[i*VARWIDTH +: VARWIDTH]))
           - DW'($signed(invec1[i*VARWIDTH +: VARWIDTH]));
      dext = TW'(diff);
      dabs = diff[DW-1] ? -diff : diff;
      sum  = sum + (use_abs ? CW'(dabs) : CW'($unsigned(dext * dext)));
    end
  end

  assign sum_sat  = |sum[CW-1:OUTWIDTH];
  assign sum_clip = sum_sat ? {OUTWIDTH{1'b1}} : sum[OUTWIDTH-1:0];
  assign add      = {1'b0, acc_q} + {1'b0, sum_clip};
  assign add_sat  = add[OUTWIDTH];
  assign acc_new  = first ? sum_clip : (add_sat ? {OUTWIDTH{1'b1}} : add[OUTWIDTH-1:0]);
  assign ovf_new  = first ? sum_sat : (ovf_q | sum_sat | add_sat);

  // One restoring square-root step: bring down two radicand bits, try (root<<2)|1.
  logic [RW-1:0]   rem_sh, trial, rem_nx;
  logic            ge;
  logic [HALF-1:0] root_nx;

  assign rem_sh  = {rem_q, rad_q[OUTWIDTH-1 -: 2]};
  assign trial   = {1'b0, root_q, 2'b01};
  assign ge      = (rem_sh >= trial);
  assign rem_nx  = ge ? (rem_sh - trial) : rem_sh;
  assign root_nx = HALF'({root_q, ge});

  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    acc_d    = acc_q;
    ovf_d    = ovf_q;
    mode_d   = mode_q;
    result_d = result_q;
    rad_d    = rad_q;
    rem_d    = rem_q;
    root_d   = root_q;
    cnt_d    = cnt_q;
    case (state_q)
      StAcc: begin
        if (in_valid) begin
          acc_d = acc_new;
          ovf_d = ovf_new;
          if (first) mode_d = mode;
          if (beat_q == BW'(BEATS - 1)) begin
            beat_d = '0;
            if (eff_mode == 2'd1) begin
              state_d = StSqrt;
              rad_d   = acc_new;
              rem_d   = '0;
              root_d  = '0;
              cnt_d   = '0;
            end else begin
              state_d  = StDone;
              result_d = acc_new;
            end
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      StSqrt: begin
        rad_d  = rad_q << 2;
        rem_d  = (RW-2)'(rem_nx);
        root_d = root_nx;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == QW'(HALF - 1)) begin
          state_d  = StDone;
          result_d = OUTWIDTH'(root_nx);
        end
      end
      StDone: begin
        if (out_ready) state_d = StAcc;
      end
      default: state_d = StAcc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StAcc;
      beat_q   <= '0;
      acc_q    <= '0;
      ovf_q    <= 1'b0;
      mode_q   <= 2'd0;
      result_q <= '0;
      rad_q    <= '0;
      rem_q    <= '0;
      root_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      acc_q    <= acc_d;
      ovf_q    <= ovf_d;
      mode_q   <= mode_d;
      result_q <= result_d;
      rad_q    <= rad_d;
      rem_q    <= rem_d;
      root_q   <= root_d;
      cnt_q    <= cnt_d;
    end
  end

  assign in_ready  = (state_q == StAcc) && !rst;
  assign out_valid = (state_q == StDone);
  assign outval    = result_q;
  assign overflow  = ovf_q;
endmodule

// File: doc/distcalc_multi.md
# distcalc_multi

Parametrised, streaming vector-distance engine: successor to the single-mode Euclidean distance calculator. Accepts two signed vectors as `BEATS` consecutive beats of `PIPEWIDTH` elements each, then produces squared-Euclidean, Euclidean (integer square root) or Manhattan distance. Valid/ready handshakes on both sides, saturating accumulation and a sticky overflow flag. It sits between the vector fetch stage and the nearest-neighbour compare logic.

## Interface
- `VARWIDTH`, 16: element width, signed two's complement.
- `PIPEWIDTH`, 8: elements per beat.
- `BEATS`, 4: beats per vector; total vector length is `PIPEWIDTH*BEATS`; must be ≥1.
- `OUTWIDTH`, 32: accumulator and result width; must be even.

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `mode`  in  2  0 = squared Euclidean, 1 = Euclidean, 2 = Manhattan, 3 = reserved (behaves as 0); sampled on the first beat of each vector.
- `in_valid`  in  1  beat present on `invec0`/`invec1`.
- `in_ready`  out  1  block accepts a beat this cycle.
- `invec0`, `invec1`  in  `VARWIDTH*PIPEWIDTH` each  element i at bits `[i*VARWIDTH +: VARWIDTH]`.
- `out_valid`  out  1  `outval`/`overflow` are valid.
- `out_ready`  in  1  consumer takes the result.
- `outval`  out  `OUTWIDTH`  distance result.
- `overflow`  out  1  accumulator saturated during this vector.

## Operation
- States: ACC, SQRT, DONE. Reset enters ACC with beat counter = 0 and accumulator = 0.
- ACC:
  - `in_ready` = 1. A beat is accepted when `in_valid && in_ready`.
  - Per element: difference d = a − b, sign-extended to `VARWIDTH+1` bits.
  - Term is d·d in modes 0, 1 and 3, and |d| in mode 2.
  - The `PIPEWIDTH` terms are summed by a combinational adder tree at full width. The sum is added to the accumulator, saturating at 2^`OUTWIDTH`−1.
  - Any saturation, whether in the term sum or in the add, sets the sticky `ovf` register.
  - On the first beat (counter = 0), the accumulator is loaded rather than added to, `ovf` is cleared, and `mode` is latched.
  - On an accepted beat with counter = `BEATS`−1: counter wraps to 0. Latched mode 1 → SQRT; otherwise → DONE with `outval` = accumulator.
- SQRT:
  - Restoring digit-by-digit integer square root, one result bit per cycle, `OUTWIDTH/2` cycles.
  - Result = floor(sqrt(acc)), zero-extended to `OUTWIDTH` bits. Then → DONE.
  - `in_ready` = 0.
- DONE:
  - `out_valid` = 1 and `in_ready` = 0.
  - `outval` and `overflow` stay stable while `out_ready` = 0.
  - On `out_valid && out_ready` → ACC; `out_valid` drops the next cycle.
- `in_valid` low in ACC: state, counter and accumulator all hold, so gaps between beats are permitted.
- Mode changes mid-vector are ignored until the next first beat.

## Timing
- Reset values, asserted the cycle after `rst` is sampled high: `in_ready` = 0 while `rst` = 1, then 1 the following cycle; `out_valid` = 0; `outval` = 0; `overflow` = 0; state ACC; counter = 0.
- Reset mid-operation, in any state, aborts the vector. No partial result is emitted.
- Let t be the cycle in which the last beat is accepted:
  - Modes 0/2/3: `out_valid` high at t+1.
  - Mode 1: `out_valid` high at t+1+`OUTWIDTH/2` (t+17 at defaults).
- Throughput: one vector per `BEATS`+1 cycles (modes 0/2), with `out_ready` held high. The first beat of the next vector is accepted in the cycle after the handshake.
- No combinational path from `out_ready` to `in_ready`, or from `in_valid` to any output.
- `rst` and a handshake in the same cycle: `rst` wins.

## Test plan
- Modes 0, 1, 2 at defaults. Beat 0: `invec0` elem0 = 3, elem1 = 4; `invec1` all 0. All other beats zero.
  - Required `outval`: 25, 5 and 7 respectively.
  - Mode 0/2 result appears 1 cycle after the last beat; mode 1 result appears 17 cycles after.
- Signed difference: a = −5, b = 3 in one element, all others equal.
  - Mode 0 → 64, mode 2 → 8, mode 1 → 8, `overflow` = 0.
- Saturation: all 32 elements a = −32768, b = 32767, mode 0.
  - Required: `outval` = 0xFFFFFFFF, `overflow` = 1.
  - Next vector all-zero: `outval` = 0, `overflow` = 0.
- Back-pressure: hold `out_ready` = 0 for 10 cycles in DONE.
  - `outval` stays stable and `in_ready` stays 0 throughout.
  - Releasing `out_ready` gives exactly one handshake; the next vector is then accepted normally.
- Gapped input: deassert `in_valid` for 3 cycles between beats 1 and 2, and toggle `mode` during the gap.
  - Result must equal the ungapped result under the originally latched mode.
- Reset mid-SQRT: assert `rst` 5 cycles into SQRT.
  - `out_valid` never rises for the aborted vector.
  - The next vector (mode 1, elem0 3 vs 0) returns 3.
